// File: rtl/ram_burst_reader.sv
// Burst read sequencer for a 1-cycle-latency RAM read port: issues one address per
// cycle under a 2-entry credit limit and streams the returned words as valid/ready.
module ram_burst_reader #(
  parameter int WORDS = 256,
  parameter int DW    = 8,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_qout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic [AW:0]   ONE_BEAT  = (AW+1)'(1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_ctr_q, addr_ctr_d;
  logic [AW:0]   issue_left_q, issue_left_d;
  logic [AW:0]   pop_left_q, pop_left_d;
  logic          inflight_q;
  logic [DW-1:0] buf_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;

  logic          cmd_fire, issue, push, pop;
  logic [2:0]    credit_used, credit_limit;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == READ);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ram_addr  = addr_ctr_q;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf_q[rd_ptr_q];
  assign out_last  = out_valid && (pop_left_q == ONE_BEAT);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;

  // Credit: buffered + in-flight words after this cycle's pop must stay below 2,
  // written as used < 2 + pop to avoid an unsigned underflow.
  assign credit_used  = {1'b0, count_q} + {2'b00, inflight_q};
  assign credit_limit = 3'd2 + {2'b00, pop};
  assign issue = (state_q == READ) && (issue_left_q != '0) && (credit_used < credit_limit);

  always_comb begin
    state_d      = state_q;
    addr_ctr_d   = addr_ctr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d      = READ;
          addr_ctr_d   = cmd_addr;
          issue_left_d = {1'b0, cmd_len} + ONE_BEAT;
          pop_left_d   = {1'b0, cmd_len} + ONE_BEAT;
        end
      end
      READ: begin
        if (issue) begin
          issue_left_d = issue_left_q - ONE_BEAT;
          addr_ctr_d   = (addr_ctr_q == LAST_ADDR) ? '0 : addr_ctr_q + AW'(1);
        end
        if (pop) begin
          pop_left_d = pop_left_q - ONE_BEAT;
          if (pop_left_q == ONE_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_ctr_q   <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_ctr_q   <= addr_ctr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (push) begin
        buf_q[wr_ptr_q] <= ram_qout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  a_cmd_addr_legal: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_fire |-> (int'(cmd_addr) < WORDS));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: randomized bursts and backpressure against a queue
// model of the expected word stream built from a RAM image.
module tb_ram_burst_reader;
  localparam int WORDS = 20;
  localparam int DW    = 8;
  localparam int AW    = $clog2(WORDS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_qout = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] got_d[$], exp_d[$];
  logic          got_l[$], exp_l[$];
  int            checks = 0;
  int            errors = 0;
  int            stall_err = 0;

  ram_burst_reader #(.WORDS(WORDS), .DW(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_addr(ram_addr), .ram_qout(ram_qout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM read port with one cycle of registered latency
  always @(posedge clk) ram_qout <= mem[ram_addr];

  task automatic fill_random();
    for (int i = 0; i < WORDS; i++) mem[i] = DW'($urandom);
  endtask

  task automatic clear_q();
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  // Expected stream: len+1 consecutive words from addr, wrapping modulo WORDS
  task automatic model(input int addr, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_d.push_back(mem[(addr + i) % WORDS]);
      exp_l.push_back(i == len);
    end
  endtask

  // Called and returns at posedge+1; handshake completes on the edge before return
  task automatic send_cmd(input int addr, input int len);
    cmd_valid = 1'b1; cmd_addr = AW'(addr); cmd_len = AW'(len);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1; cmd_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL cmd_accept: cmd_ready stayed %b, required 1 within 50 cycles", cmd_ready);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int pct, input logic use_pat,
                         input logic [15:0] pat, input int budget);
    logic          held_v;
    logic [DW-1:0] held_d;
    int            got0;
    held_v = 1'b0; held_d = '0; got0 = got_d.size();
    for (int c = 0; c < budget && (got_d.size() - got0) < n; c++) begin
      out_ready = use_pat ? pat[c % 16] : ($urandom_range(99) < pct);
      @(negedge clk);
      if (held_v && (!out_valid || out_data !== held_d)) stall_err++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last);
      end
      held_v = out_valid && !out_ready; held_d = out_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, required 00", out_data); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %0d, required 0", ram_addr); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    mem[5] = 8'hA5;
    out_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = AW'(5); cmd_len = '0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready_idle: got %b, required 1", cmd_ready); end
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_addr !== AW'(5)) begin errors++; $display("FAIL single_ram_addr: got %0d, required 5", ram_addr); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL single_busy: busy/cmd_ready got %b/%b, required 1/0", busy, cmd_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_e0: out_valid got %b, required 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_e1: out_valid got %b, required 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== mem[5] || out_last !== 1'b1) begin
      errors++; $display("FAIL single_beat: valid/data/last got %b/%h/%b, required 1/%h/1", out_valid, out_data, out_last, mem[5]);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: valid/cmd_ready/busy got %b/%b/%b, required 0/1/0", out_valid, cmd_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) mem[16 + i] = DW'(i + 1);
    out_ready = 1'b1;
    send_cmd(16, 3);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++; if (ram_addr !== AW'(16 + k)) begin errors++; $display("FAIL stream_ram_addr[%0d]: got %0d, required %0d", k, ram_addr, 16 + k); end
      end
      checks++;
      if (out_valid !== (k >= 2 && k <= 5)) begin
        errors++; $display("FAIL stream_valid[%0d]: got %b, required %b", k, out_valid, (k >= 2 && k <= 5));
      end else if (k >= 2 && k <= 5 && (out_data !== mem[16 + k - 2] || out_last !== (k == 5))) begin
        errors++; $display("FAIL stream_beat[%0d]: data/last got %h/%b, required %h/%b", k, out_data, out_last, mem[16 + k - 2], (k == 5));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int start;
    clear_q(); stall_err = 0;
    send_cmd(16, 3);
    collect(4, 0, 1'b1, 16'hFFE9, 100);
    model(16, 3);
    // Stalled from the start: only two reads may be issued ahead
    fill_random();
    start = $urandom_range(WORDS - 1);
    out_ready = 1'b0;
    send_cmd(start, 7);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (ram_addr !== AW'((start + 2) % WORDS)) begin errors++; $display("FAIL bp_credit_stall: ram_addr got %0d, required %0d", ram_addr, (start + 2) % WORDS); end
    checks++; if (out_valid !== 1'b1 || out_data !== mem[start]) begin errors++; $display("FAIL bp_head: valid/data got %b/%h, required 1/%h", out_valid, out_data, mem[start]); end
    @(posedge clk); #1;
    collect(8, 40, 1'b0, '0, 400);
    model(start, 7);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL bp_count: got %0d beats, required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL bp_beat[%0d]: data/last got %h/%b, required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: %0d stall violations, required 0", stall_err); end
  endtask

  task automatic test_wrap();
    int start;
    clear_q(); fill_random();
    send_cmd(WORDS - 2, 3);
    collect(4, 70, 1'b0, '0, 200);
    model(WORDS - 2, 3);
    for (int i = 0; i < WORDS; i++) mem[i] = DW'(i * 11 + 7);
    start = $urandom_range(WORDS - 1);
    send_cmd(start, WORDS - 1);
    collect(WORDS, 80, 1'b0, '0, 400);
    model(start, WORDS - 1);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL wrap_count: got %0d beats, required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL wrap_beat[%0d]: data/last got %h/%b, required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_cmd_while_busy();
    int a1, a2, l2, hs;
    clear_q(); fill_random();
    a1 = $urandom_range(WORDS - 1); a2 = $urandom_range(WORDS - 1); l2 = $urandom_range(5);
    model(a1, 7); model(a2, l2);
    cmd_valid = 1'b1; cmd_addr = AW'(a1); cmd_len = AW'(7); hs = 0;
    for (int c = 0; c < 300 && got_d.size() < exp_d.size(); c++) begin
      out_ready = ($urandom_range(99) < 70);
      @(negedge clk);
      if (out_valid && out_ready) begin got_d.push_back(out_data); got_l.push_back(out_last); end
      if (cmd_valid && cmd_ready) begin
        hs++;
        if (hs == 2) begin
          checks++; if (got_d.size() !== 8) begin errors++; $display("FAIL busy_second_accept: beats before accept got %0d, required 8", got_d.size()); end
        end
      end
      @(posedge clk); #1;
      if (hs == 1) begin cmd_addr = AW'(a2); cmd_len = AW'(l2); end
      if (hs == 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    checks++; if (hs !== 2) begin errors++; $display("FAIL busy_handshakes: got %0d, required 2", hs); end
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL busy_count: got %0d beats, required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL busy_beat[%0d]: data/last got %h/%b, required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int popped, stray, b;
    clear_q(); fill_random();
    out_ready = 1'b1; popped = 0; stray = 0;
    send_cmd($urandom_range(WORDS - 1), 7);
    for (int c = 0; c < 20 && popped < 2; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) popped++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rstmid_out: valid/last/data got %b/%b/%h, required 0/0/00", out_valid, out_last, out_data); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || ram_addr !== '0) begin errors++; $display("FAIL rstmid_ctrl: busy/cmd_ready/ram_addr got %b/%b/%0d, required 0/1/0", busy, cmd_ready, ram_addr); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_residual: %0d cycles with out_valid, required 0", stray); end
    @(posedge clk); #1;
    b = $urandom_range(WORDS - 1);
    send_cmd(b, 1);
    collect(2, 60, 1'b0, '0, 100);
    model(b, 1);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL rstmid_count: got %0d beats, required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL rstmid_beat[%0d]: data/last got %h/%b, required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_random();
    int a, l;
    clear_q(); stall_err = 0;
    for (int n = 0; n < 8; n++) begin
      fill_random();
      a = $urandom_range(WORDS - 1); l = $urandom_range(WORDS - 1);
      model(a, l);
      send_cmd(a, l);
      collect(l + 1, $urandom_range(100, 30), 1'b0, '0, 600);
    end
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL rand_count: got %0d beats, required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL rand_beat[%0d]: data/last got %h/%b, required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL rand_stable: %0d stall violations, required 0", stall_err); end
  endtask

  initial begin
    fill_random();
    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_cmd_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
